// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned PC_W       = 64;
  localparam int unsigned INST_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] word;
  } fetch_entry_t;

  // Fetch addresses are always instruction aligned.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instruction} entries with flush and occupancy count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_entry_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push_c, do_pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop_c  = pop_i && (cnt_q != '0);
  assign do_push_c = push_i && ((cnt_q != CW'(DEPTH)) || do_pop_c);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push_c) wr_q <= ptr_inc(wr_q);
      if (do_pop_c)  rd_q <= ptr_inc(rd_q);
      case ({do_push_c, do_pop_c})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push_c && !flush_i) begin
      mem_q[wr_q] <= push_entry_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential prefetch into a small queue, with redirect
// handling that discards the data of a request already in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   target_q, target_d;
  logic          req_q;
  logic          pop_c, push_c;
  logic [CW-1:0] count_c, occ_c;
  fetch_entry_t  head_c, push_entry_c;
  logic          head_valid_c;

  // A redirect voids any decode transfer in the same cycle.
  assign pop_c        = head_valid_c && inst_ready && !redirect;
  assign occ_c        = count_c - CW'(pop_c);
  assign push_entry_c = '{pc: pc_q, word: imem_data};

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk_i        (CLK),
    .rst_i        (resetl),
    .flush_i      (redirect),
    .push_i       (push_c),
    .push_entry_i (push_entry_c),
    .pop_i        (pop_c),
    .head_o       (head_c),
    .valid_o      (head_valid_c),
    .count_o      (count_c)
  );

  always_ff @(posedge CLK) begin
    if (resetl) begin
      state_q  <= ST_REQ;
      pc_q     <= align_pc(startpc);
      target_q <= '0;
      req_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      req_q    <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    push_c   = 1'b0;
    if (redirect) begin
      // Without an ack the old request stays on the bus until it completes.
      if ((state_q == ST_IDLE) || imem_ack) begin
        pc_d    = align_pc(redirect_pc);
        state_d = ST_REQ;
      end else begin
        target_d = align_pc(redirect_pc);
        state_d  = ST_DROP;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (occ_c < CW'(QDEPTH)) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_ack) begin
            push_c  = 1'b1;
            pc_d    = pc_q + 64'(INST_BYTES);
            // Keep requesting only if the word after this one also fits.
            state_d = (occ_c < CW'(QDEPTH - 1)) ? ST_REQ : ST_IDLE;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            pc_d    = target_q;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = head_valid_c;
  assign inst       = head_c.word;
  assign inst_pc    = head_c.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus directed redirect,
// wait-state, wrap and reset sequences, all tracked by a scoreboard.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        resetl = 1'b1;
  logic [63:0] startpc = 64'h1000;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b0;

  fetch_unit #(.QDEPTH(2)) dut (
    .CLK         (CLK),
    .resetl      (resetl),
    .startpc     (startpc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_ipc;
  } vec_t;

  exp_t        sb[$];
  logic [63:0] exp_pc = '0;
  logic [63:0] tgt = '0;
  logic        drop = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        vt[13];

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: check outputs, update the model, drive one cycle.
  task automatic apply(input logic ack, input logic rdy, input logic rd, input logic [63:0] rpc);
    logic ack_eff;
    exp_t e;
    chk("valid_vs_scoreboard", 64'(inst_valid), 64'(sb.size() != 0));
    if (inst_valid && sb.size() != 0) begin
      chk("head_pc", inst_pc, sb[0].pc);
      chk("head_word", 64'(inst), 64'(sb[0].word));
    end
    if (imem_req) chk("fetch_addr", imem_addr, exp_pc);
    ack_eff = ack && imem_req;
    if (rd) begin
      sb.delete();
      if (ack_eff) begin
        exp_pc = {rpc[63:2], 2'b00};
        drop   = 1'b0;
      end else begin
        tgt  = {rpc[63:2], 2'b00};
        drop = 1'b1;
      end
    end else begin
      if (inst_valid && rdy && sb.size() != 0) void'(sb.pop_front());
      if (ack_eff) begin
        if (drop) begin
          exp_pc = tgt;
          drop   = 1'b0;
        end else begin
          e.pc   = exp_pc;
          e.word = word_of(exp_pc);
          sb.push_back(e);
          exp_pc = exp_pc + 64'd4;
        end
      end
    end
    imem_ack    = ack_eff;
    imem_data   = word_of(imem_addr);
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Holds reset for two edges; ack_in lets a stale ack arrive during reset.
  task automatic do_reset(input logic [63:0] spc, input logic ack_in);
    resetl     = 1'b1;
    startpc    = spc;
    imem_ack   = ack_in;
    imem_data  = 32'hDEAD_BEEF;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_valid", 64'(inst_valid), 64'd0);
    end
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_req", 64'(imem_req), 64'd1);
    chk("rst_addr", imem_addr, {spc[63:2], 2'b00});
    resetl   = 1'b0;
    imem_ack = 1'b0;
    sb.delete();
    exp_pc = {spc[63:2], 2'b00};
    drop   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rst ack rdy | req addr valid inst_pc
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h1000, 1'b0, 64'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h1004, 1'b1, 64'h1000};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h1008, 1'b1, 64'h1004};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h100C, 1'b1, 64'h1008};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h100C, 1'b0, 64'h0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h1000, 1'b0, 64'h0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h1004, 1'b1, 64'h1000};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h1000};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 64'h1000};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 64'h1000};
    vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h1008, 1'b1, 64'h1004};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h100C, 1'b1, 64'h1008};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h100C, 1'b0, 64'h0};

    @(negedge CLK);
    for (int i = 0; i < 13; i++) begin
      if (vt[i].rst) do_reset(64'h1000, 1'b0);
      chk($sformatf("tbl%0d_req", i), 64'(imem_req), 64'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 64'(inst_valid), 64'(vt[i].e_valid));
      if (vt[i].e_valid) chk($sformatf("tbl%0d_inst_pc", i), inst_pc, vt[i].e_ipc);
      apply(vt[i].ack, vt[i].rdy, 1'b0, 64'h0);
    end

    // Ack delayed three cycles: address must hold until the ack.
    do_reset(64'h1000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("wait_req", 64'(imem_req), 64'd1);
      chk("wait_addr", imem_addr, 64'h1000);
      apply(k == 3, 1'b1, 1'b0, 64'h0);
    end
    chk("late_valid", 64'(inst_valid), 64'd1);
    chk("late_inst_pc", inst_pc, 64'h1000);
    apply(1'b0, 1'b1, 1'b0, 64'h0);

    // Redirect while 0x1008 is outstanding; its ack comes two cycles later.
    do_reset(64'h1000, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 64'h0);
    apply(1'b1, 1'b1, 1'b0, 64'h0);
    chk("pre_redir_addr", imem_addr, 64'h1008);
    apply(1'b0, 1'b1, 1'b1, 64'h2000);
    for (int k = 0; k < 2; k++) begin
      chk("drop_req", 64'(imem_req), 64'd1);
      chk("drop_addr", imem_addr, 64'h1008);
      chk("drop_valid", 64'(inst_valid), 64'd0);
      apply(k == 1, 1'b1, 1'b0, 64'h0);
    end
    chk("redir_addr", imem_addr, 64'h2000);
    chk("redir_valid", 64'(inst_valid), 64'd0);
    apply(1'b1, 1'b1, 1'b0, 64'h0);
    chk("redir_head_valid", 64'(inst_valid), 64'd1);
    chk("redir_head_pc", inst_pc, 64'h2000);
    apply(1'b0, 1'b1, 1'b0, 64'h0);

    // Redirect coinciding with a transfer and an ack; low target bits dropped.
    do_reset(64'h1000, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 64'h0);
    chk("coin_valid_before", 64'(inst_valid), 64'd1);
    chk("coin_pc_before", inst_pc, 64'h1000);
    apply(1'b1, 1'b1, 1'b1, 64'h3002);
    chk("coin_flushed", 64'(inst_valid), 64'd0);
    chk("coin_req", 64'(imem_req), 64'd1);
    chk("coin_addr", imem_addr, 64'h3000);
    apply(1'b1, 1'b1, 1'b0, 64'h0);
    chk("coin_head_pc", inst_pc, 64'h3000);
    apply(1'b0, 1'b1, 1'b0, 64'h0);

    // Fetch PC wraps past the top of the address space.
    do_reset(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("wrap_first_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    apply(1'b1, 1'b0, 1'b0, 64'h0);
    chk("wrap_next_addr", imem_addr, 64'h0);
    apply(1'b1, 1'b0, 1'b0, 64'h0);
    chk("wrap_head0", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    apply(1'b0, 1'b1, 1'b0, 64'h0);
    chk("wrap_head1", inst_pc, 64'h0);
    apply(1'b0, 1'b1, 1'b0, 64'h0);

    // Reset while a request is outstanding; the late ack must be ignored.
    do_reset(64'h1000, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 64'h0);
    do_reset(64'h5000, 1'b1);
    chk("rerst_addr", imem_addr, 64'h5000);
    apply(1'b0, 1'b1, 1'b0, 64'h0);
    chk("rerst_empty", 64'(inst_valid), 64'd0);
    apply(1'b1, 1'b1, 1'b0, 64'h0);
    chk("rerst_head_pc", inst_pc, 64'h5000);
    apply(1'b0, 1'b1, 1'b0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
